// File: rtl/pipearch_fp_pkg.sv
// Shared FP32 helpers for the compute datapath: compare modes and classification functions.
package pipearch_fp_pkg;

  // Codes 6 and 7 are reserved and decode to all-zero results.
  typedef enum logic [2:0] {
    CmpLt  = 3'd0,
    CmpLe  = 3'd1,
    CmpEq  = 3'd2,
    CmpNe  = 3'd3,
    CmpMin = 3'd4,
    CmpMax = 3'd5
  } cmp_mode_t;

  localparam logic [31:0] FP32_CANON_NAN = 32'h7FC0_0000;

  // Stage-1 per-lane state: raw operands plus the ordered-key compare and classification.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        key_lt;
    logic        key_eq;
    logic        a_nan;
    logic        b_nan;
    logic        both_zero;
  } cmp_s1_t;

  function automatic logic fp32_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic fp32_is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

  // Maps FP32 onto an unsigned total order (negatives inverted, positives offset).
  function automatic logic [31:0] fp32_key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/float_compare_lane.sv
// Single-lane compare: stage-1 key compare/classification, then the stage-2 flag/data select.
module float_compare_lane
  import pipearch_fp_pkg::*;
#(
  parameter bit RegStage1 = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s0_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  cmp_mode_t   s1_mode,
  output logic        flag_d,
  output logic [31:0] data_d
);

  cmp_s1_t s1_d;
  cmp_s1_t s1_q;

  // Stage-1 combinational classification of the incoming operands
  always_comb begin
    s1_d.a         = a;
    s1_d.b         = b;
    s1_d.key_lt    = fp32_key(a) < fp32_key(b);
    s1_d.key_eq    = fp32_key(a) == fp32_key(b);
    s1_d.a_nan     = fp32_is_nan(a);
    s1_d.b_nan     = fp32_is_nan(b);
    s1_d.both_zero = fp32_is_zero(a) && fp32_is_zero(b);
  end

  if (RegStage1) begin : g_s1_reg
    // Stage-1 register, loaded only by a valid beat
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_q <= '0;
      end else if (s0_valid) begin
        s1_q <= s1_d;
      end
    end
  end else begin : g_s1_bypass
    assign s1_q = s1_d;
  end

  logic lt, eq, gt, any_nan;
  assign lt      = s1_q.key_lt & ~s1_q.both_zero;
  assign eq      = s1_q.key_eq | s1_q.both_zero;
  assign gt      = ~lt & ~eq;
  assign any_nan = s1_q.a_nan | s1_q.b_nan;

  // Stage-2 select: predicate and MIN/MAX value with NaN and signed-zero handling
  always_comb begin
    flag_d = 1'b0;
    data_d = 32'd0;
    case (s1_mode)
      CmpLt: flag_d = ~any_nan & lt;
      CmpLe: flag_d = ~any_nan & (lt | eq);
      CmpEq: flag_d = ~any_nan & eq;
      CmpNe: flag_d = any_nan | ~eq;
      CmpMin: begin
        if (s1_q.a_nan && s1_q.b_nan)  data_d = FP32_CANON_NAN;
        else if (s1_q.a_nan)           data_d = s1_q.b;
        else if (s1_q.b_nan)           data_d = s1_q.a;
        else if (s1_q.both_zero)       data_d = s1_q.a | s1_q.b;  // -0 wins
        else begin
          flag_d = lt;
          data_d = lt ? s1_q.a : s1_q.b;
        end
      end
      CmpMax: begin
        if (s1_q.a_nan && s1_q.b_nan)  data_d = FP32_CANON_NAN;
        else if (s1_q.a_nan)           data_d = s1_q.b;
        else if (s1_q.b_nan)           data_d = s1_q.a;
        else if (s1_q.both_zero)       data_d = s1_q.a & s1_q.b;  // +0 wins
        else begin
          flag_d = gt;
          data_d = gt ? s1_q.a : s1_q.b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/float_compare_vec.sv
// Multi-lane pipelined FP32 compare with per-beat mode, any/all reduction and fixed latency.
module float_compare_vec
  import pipearch_fp_pkg::*;
#(
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [2:0]             in_mode,
  input  logic [NUM_LANES*32-1:0] in1,
  input  logic [NUM_LANES*32-1:0] in2,
  output logic                   q_valid,
  output logic [NUM_LANES-1:0]   q_flag,
  output logic [NUM_LANES*32-1:0] q_data,
  output logic                   q_any,
  output logic                   q_all
);

  localparam int Extra = (LATENCY > 2) ? int'(LATENCY) - 2 : 0;

  logic      s0_valid;
  logic      s1_valid;
  cmp_mode_t s1_mode;

  assign s0_valid = in_valid & ~reset;

  if (LATENCY >= 2) begin : g_s1
    logic      v1_q;
    cmp_mode_t mode1_q;

    // Stage-1 valid and mode travel alongside the lane stage-1 registers
    always_ff @(posedge clk) begin
      if (reset) begin
        v1_q    <= 1'b0;
        mode1_q <= CmpLt;
      end else begin
        v1_q <= s0_valid;
        if (s0_valid) mode1_q <= cmp_mode_t'(in_mode);
      end
    end

    assign s1_valid = v1_q;
    assign s1_mode  = mode1_q;
  end else begin : g_s1_comb
    assign s1_valid = s0_valid;
    assign s1_mode  = cmp_mode_t'(in_mode);
  end

  logic [NUM_LANES-1:0]    flag_d;
  logic [NUM_LANES*32-1:0] data_d;

  for (genvar i = 0; i < int'(NUM_LANES); i++) begin : g_lane
    float_compare_lane #(
      .RegStage1(LATENCY >= 2)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .s0_valid(s0_valid),
      .a       (in1[i*32 +: 32]),
      .b       (in2[i*32 +: 32]),
      .s1_mode (s1_mode),
      .flag_d  (flag_d[i]),
      .data_d  (data_d[i*32 +: 32])
    );
  end

  // Index 0 is the stage-2 result register; higher indices are pure delay stages.
  logic                    vld_q  [Extra+1];
  logic [NUM_LANES-1:0]    flag_q [Extra+1];
  logic [NUM_LANES*32-1:0] data_q [Extra+1];
  logic                    any_q  [Extra+1];
  logic                    all_q  [Extra+1];

  // Stage-2 register plus delay chain; data loads only when the feeding stage is valid
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= Extra; i++) begin
        vld_q[i]  <= 1'b0;
        flag_q[i] <= '0;
        data_q[i] <= '0;
        any_q[i]  <= 1'b0;
        all_q[i]  <= 1'b0;
      end
    end else begin
      vld_q[0] <= s1_valid;
      if (s1_valid) begin
        flag_q[0] <= flag_d;
        data_q[0] <= data_d;
        any_q[0]  <= |flag_d;
        all_q[0]  <= &flag_d;
      end
      for (int i = 1; i <= Extra; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          flag_q[i] <= flag_q[i-1];
          data_q[i] <= data_q[i-1];
          any_q[i]  <= any_q[i-1];
          all_q[i]  <= all_q[i-1];
        end
      end
    end
  end

  assign q_valid = vld_q[Extra];
  assign q_flag  = flag_q[Extra];
  assign q_data  = data_q[Extra];
  assign q_any   = any_q[Extra];
  assign q_all   = all_q[Extra];

endmodule

// File: tb/tb_float_compare_vec.sv
// Directed bench for float_compare_vec: three instances (LATENCY 1, 2, 5) share one stimulus table.
module tb_float_compare_vec;

  localparam int NL   = 4;
  localparam int NROW = 128;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [2:0]   in_mode = 3'd0;
  logic [127:0] in1 = '0;
  logic [127:0] in2 = '0;

  logic         v_l1, v_l2, v_l5;
  logic [3:0]   f_l1, f_l2, f_l5;
  logic [127:0] d_l1, d_l2, d_l5;
  logic         an_l1, an_l2, an_l5;
  logic         al_l1, al_l2, al_l5;

  always #5 clk = ~clk;

  float_compare_vec #(.NUM_LANES(NL), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_mode(in_mode), .in1(in1), .in2(in2),
    .q_valid(v_l1), .q_flag(f_l1), .q_data(d_l1), .q_any(an_l1), .q_all(al_l1)
  );
  float_compare_vec #(.NUM_LANES(NL), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_mode(in_mode), .in1(in1), .in2(in2),
    .q_valid(v_l2), .q_flag(f_l2), .q_data(d_l2), .q_any(an_l2), .q_all(al_l2)
  );
  float_compare_vec #(.NUM_LANES(NL), .LATENCY(5)) u_dut_l5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_mode(in_mode), .in1(in1), .in2(in2),
    .q_valid(v_l5), .q_flag(f_l5), .q_data(d_l5), .q_any(an_l5), .q_all(al_l5)
  );

  int total = 0;
  int bad   = 0;

  // Per-cycle stimulus table with optional hand-computed expectations per beat.
  bit           s_rst  [NROW];
  bit           s_v    [NROW];
  logic [2:0]   s_m    [NROW];
  logic [127:0] s_a    [NROW];
  logic [127:0] s_b    [NROW];
  bit           h_on   [NROW];
  logic [3:0]   h_flag [NROW];
  logic [31:0]  h_d0   [NROW];
  int           nrow = 0;

  // Last valid result seen at each instance's output (0 after reset).
  logic [3:0]   hold_f [3];
  logic [127:0] hold_d [3];

  logic [31:0]  pool [12];

  function automatic logic [127:0] rep4(input logic [31:0] x);
    return {x, x, x, x};
  endfunction

  // Reference behaviour of one lane, written directly from the mode definitions.
  function automatic void model_lane(input logic [2:0] m, input logic [31:0] a,
                                     input logic [31:0] b, output logic f,
                                     output logic [31:0] d);
    logic nan_a, nan_b, zab, ordered, less, equal, greater;
    logic [31:0] ka, kb;
    nan_a   = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nan_b   = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    zab     = (a[30:0] == 0) && (b[30:0] == 0);
    ka      = a[31] ? ~a : {~a[31], a[30:0]};
    kb      = b[31] ? ~b : {~b[31], b[30:0]};
    ordered = !nan_a && !nan_b;
    equal   = ordered && (zab || a == b);
    less    = ordered && !zab && (ka < kb);
    greater = ordered && !less && !equal;
    f = 1'b0;
    d = 32'd0;
    case (m)
      3'd0: f = less;
      3'd1: f = less || equal;
      3'd2: f = equal;
      3'd3: f = !equal;
      3'd4: begin
        f = less;
        if (!ordered)  d = (nan_a && nan_b) ? 32'h7FC0_0000 : (nan_a ? b : a);
        else if (zab)  d = a[31] ? a : b;
        else           d = less ? a : b;
      end
      3'd5: begin
        f = greater;
        if (!ordered)  d = (nan_a && nan_b) ? 32'h7FC0_0000 : (nan_a ? b : a);
        else if (zab)  d = a[31] ? b : a;
        else           d = greater ? a : b;
      end
      default: ;
    endcase
  endfunction

  function automatic void model_beat(input logic [2:0] m, input logic [127:0] a,
                                     input logic [127:0] b, output logic [3:0] f,
                                     output logic [127:0] d);
    logic        lf;
    logic [31:0] ld;
    for (int i = 0; i < NL; i++) begin
      model_lane(m, a[i*32 +: 32], b[i*32 +: 32], lf, ld);
      f[i]          = lf;
      d[i*32 +: 32] = ld;
    end
  endfunction

  task automatic put(input bit rst, input bit v, input logic [2:0] m,
                     input logic [127:0] a, input logic [127:0] b);
    s_rst[nrow] = rst;
    s_v[nrow]   = v;
    s_m[nrow]   = m;
    s_a[nrow]   = a;
    s_b[nrow]   = b;
    h_on[nrow]  = 1'b0;
    nrow++;
  endtask

  task automatic hand(input logic [3:0] f, input logic [31:0] d0);
    h_on[nrow-1]   = 1'b1;
    h_flag[nrow-1] = f;
    h_d0[nrow-1]   = d0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks one instance in the cycle after clock edge c against the table.
  task automatic check_dut(input int d, input int lat, input int c, input logic v,
                           input logic [3:0] f, input logic [127:0] dt,
                           input logic an, input logic al);
    int           s;
    bit           ev;
    logic [3:0]   mf;
    logic [127:0] md;
    string        pfx;
    s   = c + 1 - lat;
    ev  = 1'b0;
    pfx = $sformatf("L%0d c%0d", lat, c);
    if (s >= 0) begin
      ev = s_v[s];
      for (int k = s; k <= c; k++) if (s_rst[k]) ev = 1'b0;
    end
    if (ev) begin
      model_beat(s_m[s], s_a[s], s_b[s], mf, md);
      hold_f[d] = mf;
      hold_d[d] = md;
      if (h_on[s]) begin
        chk({pfx, " hand_flag"}, 128'(f), 128'(h_flag[s]));
        chk({pfx, " hand_data0"}, 128'(dt[31:0]), 128'(h_d0[s]));
      end
    end else if (s_rst[c]) begin
      hold_f[d] = '0;
      hold_d[d] = '0;
    end
    chk({pfx, " valid"}, 128'(v), 128'(ev));
    chk({pfx, " flag"}, 128'(f), 128'(hold_f[d]));
    chk({pfx, " data"}, dt, hold_d[d]);
    chk({pfx, " any"}, 128'(an), 128'(|hold_f[d]));
    chk({pfx, " all"}, 128'(al), 128'(&hold_f[d]));
  endtask

  initial begin
    logic [127:0] a, b;
    for (int d = 0; d < 3; d++) begin
      hold_f[d] = '0;
      hold_d[d] = '0;
    end
    pool = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
             32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h0000_0001,
             32'h8000_0001, 32'h4000_0000, 32'h7F7F_FFFF, 32'hFFC0_0000};

    // Initial reset
    for (int i = 0; i < 3; i++) put(1, 0, 3'd0, '0, '0);

    // Directed beats with hand-computed flags and lane-0 data
    put(0, 1, 3'd0, {32'h0, 32'h0, 32'h4000_0000, 32'h3F80_0000},
                    {32'h0, 32'h0, 32'h3F80_0000, 32'h4000_0000});
    hand(4'b0001, 32'h0);
    put(0, 1, 3'd2, rep4(32'h8000_0000), rep4(32'h0000_0000)); hand(4'b1111, 32'h0);
    put(0, 1, 3'd4, rep4(32'h8000_0000), rep4(32'h0000_0000)); hand(4'b0000, 32'h8000_0000);
    put(0, 1, 3'd5, rep4(32'h8000_0000), rep4(32'h0000_0000)); hand(4'b0000, 32'h0000_0000);
    put(0, 1, 3'd0, rep4(32'h7FC0_0000), rep4(32'hBF80_0000)); hand(4'b0000, 32'h0);
    put(0, 1, 3'd3, rep4(32'h7FC0_0000), rep4(32'hBF80_0000)); hand(4'b1111, 32'h0);
    put(0, 1, 3'd4, rep4(32'h7FC0_0000), rep4(32'hBF80_0000)); hand(4'b0000, 32'hBF80_0000);
    put(0, 1, 3'd5, rep4(32'h7FC0_0000), rep4(32'hFFC0_0000)); hand(4'b0000, 32'h7FC0_0000);
    put(0, 1, 3'd0, rep4(32'hFF80_0000), rep4(32'h8000_0001)); hand(4'b1111, 32'h0);
    put(0, 1, 3'd5, rep4(32'h7F80_0000), rep4(32'h7F7F_FFFF)); hand(4'b1111, 32'h7F80_0000);
    put(0, 1, 3'd6, rep4(32'h3F80_0000), rep4(32'h4000_0000)); hand(4'b0000, 32'h0);
    put(0, 1, 3'd7, rep4(32'h4000_0000), rep4(32'h3F80_0000)); hand(4'b0000, 32'h0);
    for (int i = 0; i < 3; i++) put(0, 0, 3'd0, '0, '0);

    // Streaming: 20 back-to-back beats cycling through all mode codes
    for (int i = 0; i < 20; i++) begin
      for (int l = 0; l < NL; l++) begin
        a[l*32 +: 32] = pool[(i * 3 + l) % 12];
        b[l*32 +: 32] = pool[(i * 5 + l * 2 + 1) % 12];
      end
      put(0, 1, 3'(i % 8), a, b);
    end
    for (int i = 0; i < 6; i++) put(0, 0, 3'd0, '0, '0);

    // Reset with two beats in flight; in_valid during reset must be ignored
    put(0, 1, 3'd3, rep4(32'h3F80_0000), rep4(32'h4000_0000));
    put(0, 1, 3'd1, rep4(32'h4000_0000), rep4(32'h4000_0000));
    put(1, 1, 3'd3, rep4(32'h3F80_0000), rep4(32'h4000_0000));
    put(1, 0, 3'd0, '0, '0);
    for (int i = 0; i < 5; i++) put(0, 0, 3'd0, '0, '0);
    put(1, 0, 3'd0, '0, '0);
    // Beat on the first cycle after reset
    put(0, 1, 3'd4, rep4(32'hBF80_0000), rep4(32'h3F80_0000)); hand(4'b1111, 32'hBF80_0000);
    for (int i = 0; i < 7; i++) put(0, 0, 3'd0, '0, '0);

    for (int c = 0; c < nrow; c++) begin
      @(negedge clk);
      reset    = s_rst[c];
      in_valid = s_v[c];
      in_mode  = s_m[c];
      in1      = s_a[c];
      in2      = s_b[c];
      @(posedge clk);
      #1;
      check_dut(0, 1, c, v_l1, f_l1, d_l1, an_l1, al_l1);
      check_dut(1, 2, c, v_l2, f_l2, d_l2, an_l2, al_l2);
      check_dut(2, 5, c, v_l5, f_l5, d_l5, an_l5, al_l5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
